// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and helpers for the ROM read-port arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Request/response and ROM-side bus of the ROM read arbiter.
interface rom_read_arbiter_if #(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_data;
  logic [NUM_REQ-1:0]               rsp_ready;
  logic [ADDRESS_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]            rom_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready, rom_data,
    output req_ready, rsp_valid, rsp_data, rom_addr
  );

  modport master (
    output req_valid, req_addr, rsp_ready, rom_data,
    input  req_ready, rsp_valid, rsp_data, rom_addr
  );
endinterface

// File: rtl/rom_read_arbiter_rr_arbiter.sv
// Request arbiter: round-robin by default, fixed lowest-index priority
// when ROM_ARB_FIXED_PRIO_EN is defined (no pointer register then).
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] grant_s;
  logic               found_s;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Lowest index among valid requesters wins.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_s[k] = req_i[k] & ~found_s;
      found_s    = found_s | req_i[k];
    end
  end
`else
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] cand_s;

  // Evaluate the search from every pointer position, keep the live one.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      found_s = 1'b0;
      cand_s  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_s[(p + k) % NUM_REQ] = req_i[(p + k) % NUM_REQ] & ~found_s;
        found_s = found_s | req_i[(p + k) % NUM_REQ];
      end
      grant_s = grant_s | (cand_s & {NUM_REQ{ptr_q == IDX_W'(p)}});
    end
  end

  // Pointer moves just past the winner on every accept.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : idx_o + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= {IDX_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign grant_o = grant_s;
  assign idx_o   = onehot_to_idx(MAX_REQ'(grant_s));

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-output ROM read port among NUM_REQ requesters.
// Arbitration policy selectable with ROM_ARB_FIXED_PRIO_EN (see rr_arbiter).
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int NUM_REQ       = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  rom_read_arbiter_if.slave   bus
);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [DATA_WIDTH-1:0]    hold_q, hold_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;

  logic [NUM_REQ-1:0]       grant_s, owner_oh_s, req_ready_s, rsp_valid_s;
  logic [IDX_W-1:0]         grant_idx_s;
  logic [ADDRESS_WIDTH-1:0] win_addr_s;
  logic [DATA_WIDTH-1:0]    rsp_data_s;
  logic                     accept_s, owner_ready_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (bus.req_valid),
    .advance_i (accept_s),
    .grant_o   (grant_s),
    .idx_o     (grant_idx_s)
  );

  // Winner address mux and owner decode.
  always_comb begin
    win_addr_s = '0;
    owner_oh_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_addr_s    = win_addr_s | (bus.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] & {ADDRESS_WIDTH{grant_s[i]}});
      owner_oh_s[i] = (owner_q == IDX_W'(i));
    end
  end

  assign owner_ready_s = |(bus.rsp_ready & owner_oh_s);

  // Read-slot FSM: next state, response routing and accept.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    req_ready_s = '0;
    rsp_valid_s = '0;
    rsp_data_s  = '0;
    accept_s    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_s = grant_s;
        accept_s    = |grant_s;
        state_d     = accept_s ? DATA : IDLE;
      end
      DATA: begin
        rsp_valid_s = owner_oh_s;
        rsp_data_s  = bus.rom_data;
        if (owner_ready_s) begin
          req_ready_s = grant_s;
          accept_s    = |grant_s;
          state_d     = accept_s ? DATA : IDLE;
        end else begin
          // ROM output only lasts one cycle; keep it for the stalled owner.
          hold_d  = bus.rom_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        rsp_valid_s = owner_oh_s;
        rsp_data_s  = hold_q;
        state_d     = owner_ready_s ? IDLE : HOLD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Owner and address bookkeeping for the accepted request.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    if (accept_s) begin
      owner_d = grant_idx_s;
      addr_d  = win_addr_s;
    end else begin
      owner_d = owner_q;
      addr_d  = addr_q;
    end
  end

  // State, owner, hold and address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= {IDX_W{1'b0}};
      hold_q  <= {DATA_WIDTH{1'b0}};
      addr_q  <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = rsp_data_s;
  assign bus.rom_addr  = accept_s ? win_addr_s : addr_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter against a transaction-level model;
// follows ROM_ARB_FIXED_PRIO_EN for the expected arbitration policy.
module tb_rom_read_arbiter;
  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  // Model: the one outstanding response (if any) plus arbitration pointer.
  bit            m_busy, m_stalled;
  int            m_owner, m_ptr;
  logic [AW-1:0] m_addr, m_last;

  logic [N-1:0]  obs_rr, obs_rv;
  logic [DW-1:0] obs_rd;
  logic [AW-1:0] obs_ra;

  rom_read_arbiter_if #(.NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_read_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] ad);
    if (ad == 12'h005) return 32'hDEADBEEF;
    return {ad, 20'h0} ^ (32'(ad) * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  function automatic logic [N*AW-1:0] pk(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    return {a1, a0};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with one-cycle registered output.
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_stalled = 0; m_owner = 0; m_ptr = 0; m_addr = '0; m_last = '0;
  endtask

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N-1:0] rr);
    int            win;
    bit            acc, own_rdy;
    logic [N-1:0]  e_rr, e_rv;
    logic [DW-1:0] e_rd;
    logic [AW-1:0] e_ra;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = rr;
    #2;
    win = -1;
    for (int k = 0; k < N; k++) begin
      if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    own_rdy = m_busy && rr[m_owner];
    acc     = (win >= 0) && (!m_busy || (!m_stalled && own_rdy));
    e_rr = '0;
    if (acc) e_rr[win] = 1'b1;
    e_rv = '0;
    if (m_busy) e_rv[m_owner] = 1'b1;
    e_rd = m_busy ? rom_fn(m_addr) : '0;
    e_ra = acc ? a[win*AW +: AW] : m_last;
    obs_rr = bus.req_ready;
    obs_rv = bus.rsp_valid;
    obs_rd = bus.rsp_data;
    obs_ra = bus.rom_addr;
    chk("req_ready", DW'(obs_rr), DW'(e_rr));
    chk("rsp_valid", DW'(obs_rv), DW'(e_rv));
    chk("rsp_data",  obs_rd, e_rd);
    chk("rom_addr",  DW'(obs_ra), DW'(e_ra));
    @(posedge clk);
    if (own_rdy) m_busy = 0;
    else if (m_busy) m_stalled = 1;
    if (acc) begin
      m_busy = 1; m_stalled = 0; m_owner = win;
      m_addr = a[win*AW +: AW];
      m_last = m_addr;
`ifdef ROM_ARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (win + 1) % N;
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.rsp_ready = '0;
    model_reset();
    #12;
    chk("rst_req_ready", DW'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", DW'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data",  bus.rsp_data, 32'h0);
    chk("rst_rom_addr",  DW'(bus.rom_addr), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single request
    step(2'b01, pk(12'h000, 12'h005), 2'b11);
    chk("single_grant", DW'(obs_rr), 32'h1);
    step(2'b00, '0, 2'b11);
    chk("single_valid", DW'(obs_rv), 32'h1);
    chk("single_data", obs_rd, 32'hDEADBEEF);
    step(2'b00, '0, 2'b11);
    chk("single_idle", DW'(obs_rv), 32'h0);

    // Contention
    for (int i = 0; i < 6; i++) step(2'b11, pk(12'h020, 12'h010), 2'b11);
    step(2'b00, '0, 2'b11);
    step(2'b00, '0, 2'b11);

    // Stall with req0 waiting
    step(2'b10, pk(12'h003, 12'h000), 2'b11);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, pk(12'h000, 12'h044), 2'b01);
      chk("stall_ready", DW'(obs_rr), 32'h0);
      chk("stall_data", obs_rd, rom_fn(12'h003));
    end
    step(2'b01, pk(12'h000, 12'h044), 2'b11);
    chk("hold_exit_ready", DW'(obs_rr), 32'h0);
    step(2'b01, pk(12'h000, 12'h044), 2'b11);
    chk("after_hold_grant", DW'(obs_rr), 32'h1);
    step(2'b00, '0, 2'b11);
    step(2'b00, '0, 2'b11);

    // Withdrawal while in HOLD
    step(2'b01, pk(12'h000, 12'h007), 2'b11);
    step(2'b00, '0, 2'b10);
    step(2'b10, pk(12'h055, 12'h000), 2'b10);
    chk("withdraw_ready", DW'(obs_rr), 32'h0);
    step(2'b00, '0, 2'b10);
    step(2'b00, '0, 2'b11);
    step(2'b00, '0, 2'b11);
    chk("withdraw_no_rsp", DW'(obs_rv), 32'h0);

    // Back-to-back single requester
    step(2'b01, pk(12'h000, 12'h001), 2'b11);
    step(2'b01, pk(12'h000, 12'h002), 2'b11);
    chk("b2b_data1", obs_rd, rom_fn(12'h001));
    step(2'b01, pk(12'h000, 12'h003), 2'b11);
    chk("b2b_data2", obs_rd, rom_fn(12'h002));
    step(2'b00, '0, 2'b11);
    chk("b2b_data3", obs_rd, rom_fn(12'h003));
    chk("b2b_valid3", DW'(obs_rv), 32'h1);
    step(2'b00, '0, 2'b11);

    // Reset during the DATA cycle
    step(2'b01, pk(12'h000, 12'h0AA), 2'b11);
    bus.req_valid = '0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", DW'(bus.rsp_valid), 32'h0);
    chk("async_rst_data", bus.rsp_data, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(2'b00, '0, 2'b11);
    chk("post_rst_no_rsp", DW'(obs_rv), 32'h0);
    step(2'b00, '0, 2'b11);
    step(2'b11, pk(12'h0B1, 12'h0B0), 2'b11);
    chk("post_rst_ptr0", DW'(obs_rr), 32'h1);
    step(2'b00, '0, 2'b11);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom_range(0, 3)),
           pk(AW'($urandom), AW'($urandom)),
           {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
